score_counter: RTL and testbench
================================

// Module: score_counter
// PURPOSE
//   Keeps the running game score as packed BCD digits and drives score_render in place of its constant num input.
//   Also holds the session high score and a speed level for the obstacle stage.
//   Counts 60 Hz game ticks while a game is running, freezes on crash, clears on game start.
//   Sits between player_controller/graphics_top (pulse sources) and score_render/obstacles (consumers).
// PARAMETERS
//   NUM_DIGITS       4   BCD digits in score and high score (score max = 10^NUM_DIGITS - 1)
//   TICKS_PER_POINT  6   60 Hz ticks per score point (6 -> 10 points/s); legal range 1..255
//   MAX_LEVEL        7   speed level saturation value (fits o_speed_level)
// PORTS
//   clk                 in   1             system clock (same clk as graphics_top)
//   rst                 in   1             synchronous reset, active-high
//   i_game_tick         in   1             1-cycle pulse, 60 Hz frame tick
//   i_game_start_pulse  in   1             1-cycle pulse, new game begins
//   i_game_over_pulse   in   1             1-cycle pulse, crash detected
//   o_score             out  4*NUM_DIGITS  current score, packed BCD, digit 0 in [3:0]
//   o_high_score        out  4*NUM_DIGITS  best score this power-up, packed BCD
//   o_new_high          out  1             high score beaten in the last finished game
//   o_speed_level       out  3             +1 per 100 points, saturates at MAX_LEVEL
//   o_milestone_pulse   out  1             1-cycle pulse each time score crosses a multiple of 100
// BEHAVIOUR
//   - Reset is synchronous and active-high: on rst, state=IDLE, prescaler=0, all outputs 0.
//   - FSM states are IDLE, RUNNING and OVER.
//     IDLE --start--> RUNNING; RUNNING --over--> OVER; OVER --start--> RUNNING.
//     over pulse in IDLE/OVER is ignored; start in RUNNING restarts the game (clears score, stays RUNNING).
//   - On start: score=0, prescaler=0, speed_level=0, o_new_high=0.
//     The start takes effect in the cycle after the pulse.
//   - In RUNNING, each i_game_tick increments the prescaler.
//     When the prescaler reaches TICKS_PER_POINT-1 on a tick, it wraps to 0 and the score increments by 1.
//     The new score is visible on o_score the cycle after that tick (1-cycle latency).
//   - BCD increment is one-cycle ripple: a digit at 9 goes to 0 and carries to the next digit.
//     At all-9s the score saturates (no wrap) and the prescaler keeps running.
//   - Milestone: when an increment carries out of digit 1 into digit 2 (e.g. 0099->0100), o_milestone_pulse=1 for exactly that update cycle.
//     On the same edge, speed_level increments unless it is already MAX_LEVEL.
//     No milestone on saturation.
//   - On over (RUNNING): the score freezes and the state goes to OVER.
//     If score > high_score (BCD magnitude compare, MS digit first), then high_score <= score and o_new_high <= 1 on that edge.
//   - Simultaneous events:
//     start + over in the same cycle: start wins (over ignored).
//     start + tick: the tick is dropped.
//     over + point-completing tick: the increment is dropped and the frozen score is the pre-tick value.
//   - Ticks in IDLE/OVER do nothing. o_high_score is cleared only by rst.
//   - rst asserted mid-game: the next edge returns everything to reset values regardless of pulses.
// TESTING
//   1. rst 2 cycles, then 20 ticks, no start -> o_score=0x0000, o_speed_level=0, state IDLE.
//   2. start, then 60 ticks (TPP=6) -> o_score=0x0010; o_score changes only on the cycle after every 6th tick.
//   3. Preload by running to 0x0099, then 6 ticks -> o_score=0x0100, o_milestone_pulse high 1 cycle, o_speed_level=1.
//   4. Game to 0x0042 then over -> o_high_score=0x0042, o_new_high=1.
//      start, reach 0x0030, over -> high stays 0x0042, o_new_high=0.
//   5. over coincident with the 6th tick at score 0x0007 -> frozen o_score=0x0007.
//      start+over same cycle -> RUNNING, score 0.
//   6. Force the score to 0x9999 and tick 12 -> stays 0x9999, no milestone.
//      Then assert rst mid-RUNNING -> all outputs 0 next cycle.

Source files
------------

// File: rtl/score_counter.sv
// rtl/score_counter.sv - packed-BCD game score, session high score and speed level
//
// Purpose:
//   Counts 60 Hz game ticks while a game is running and turns every
//   TICKS_PER_POINT ticks into one score point, kept as packed BCD for
//   score_render.  Freezes on crash, clears on game start, keeps the best
//   score since reset and a speed level for the obstacle stage.
//
// Ports:
//   clk                 system clock (shared with graphics_top)
//   rst                 synchronous reset, active-high
//   i_game_tick         1-cycle pulse, 60 Hz frame tick
//   i_game_start_pulse  1-cycle pulse, new game begins (also restarts a running game)
//   i_game_over_pulse   1-cycle pulse, crash detected
//   o_score             current score, packed BCD, digit 0 in [3:0]
//   o_high_score        best score since reset, packed BCD
//   o_new_high          the last finished game set a new high score
//   o_speed_level       +1 per 100 points, saturates at MAX_LEVEL
//   o_milestone_pulse   1-cycle pulse when the score reaches a multiple of 100

module score_counter #(
   parameter int NUM_DIGITS      = 4,
   parameter int TICKS_PER_POINT = 6,
   parameter int MAX_LEVEL       = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_game_tick,
   input  logic                    i_game_start_pulse,
   input  logic                    i_game_over_pulse,
   output logic [4*NUM_DIGITS-1:0] o_score,
   output logic [4*NUM_DIGITS-1:0] o_high_score,
   output logic                    o_new_high,
   output logic [2:0]              o_speed_level,
   output logic                    o_milestone_pulse
);

   localparam int SW = 4 * NUM_DIGITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUNNING,
      S_OVER
   } state_t;

   state_t        r_state,     w_state_next;
   logic [7:0]    r_presc,     w_presc_next;
   logic [SW-1:0] r_score,     w_score_next;
   logic [SW-1:0] r_high,      w_high_next;
   logic          r_new_high,  w_new_high_next;
   logic [2:0]    r_level,     w_level_next;
   logic          r_milestone, w_milestone_next;

   logic [SW-1:0] w_score_inc;
   logic          w_saturated;
   logic          w_cross_100;
   logic          w_point;

   // Ripple BCD +1: each digit at 9 rolls to 0 and passes the carry on.
   // A carry surviving past the top digit means the score is all 9s.
   always_comb begin : bcd_inc
      logic v_carry;
      v_carry     = 1'b1;
      w_score_inc = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (v_carry && (r_score[4*d +: 4] == 4'd9)) begin
            w_score_inc[4*d +: 4] = 4'd0;
         end else begin
            w_score_inc[4*d +: 4] = r_score[4*d +: 4] + {3'b000, v_carry};
            v_carry               = 1'b0;
         end
      end
      w_saturated = v_carry;
   end

   // Carry out of digit 1 into digit 2 happens exactly when the low two
   // digits read 99; at all-9s the score holds, so no milestone.
   assign w_cross_100 = (r_score[7:0] == 8'h99) && !w_saturated;
   assign w_point     = i_game_tick && (r_presc == 8'(TICKS_PER_POINT - 1));

   always_comb begin
      w_state_next     = r_state;
      w_presc_next     = r_presc;
      w_score_next     = r_score;
      w_high_next      = r_high;
      w_new_high_next  = r_new_high;
      w_level_next     = r_level;
      w_milestone_next = 1'b0;

      // Start outranks both a coincident crash and a coincident tick.
      if (i_game_start_pulse) begin
         w_state_next    = S_RUNNING;
         w_presc_next    = 8'd0;
         w_score_next    = '0;
         w_level_next    = 3'd0;
         w_new_high_next = 1'b0;
      end else begin
         case (r_state)
            S_RUNNING: begin
               if (i_game_over_pulse) begin
                  // Crash freezes the pre-tick score.  Nibbles never exceed 9,
                  // so a plain unsigned compare of packed BCD is a magnitude compare.
                  w_state_next = S_OVER;
                  if (r_score > r_high) begin
                     w_high_next     = r_score;
                     w_new_high_next = 1'b1;
                  end
               end else if (i_game_tick) begin
                  if (w_point) begin
                     w_presc_next = 8'd0;
                     if (!w_saturated) begin
                        w_score_next     = w_score_inc;
                        w_milestone_next = w_cross_100;
                        if (w_cross_100 && (r_level != 3'(MAX_LEVEL))) begin
                           w_level_next = r_level + 3'd1;
                        end
                     end
                  end else begin
                     w_presc_next = r_presc + 8'd1;
                  end
               end
            end
            default: begin
               // IDLE and OVER ignore ticks and crash pulses.
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_presc     <= 8'd0;
         r_score     <= '0;
         r_high      <= '0;
         r_new_high  <= 1'b0;
         r_level     <= 3'd0;
         r_milestone <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_presc     <= w_presc_next;
         r_score     <= w_score_next;
         r_high      <= w_high_next;
         r_new_high  <= w_new_high_next;
         r_level     <= w_level_next;
         r_milestone <= w_milestone_next;
      end
   end

   assign o_score           = r_score;
   assign o_high_score      = r_high;
   assign o_new_high        = r_new_high;
   assign o_speed_level     = r_level;
   assign o_milestone_pulse = r_milestone;

endmodule

// File: tb/tb_score_counter.sv
// tb/tb_score_counter.sv - self-checking bench for score_counter

module tb_score_counter;

   localparam int TPP  = 6;
   localparam int ML   = 7;
   localparam int MAXS = 9999;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance, default parameters
   logic        rst = 1'b1, tick = 1'b0, start = 1'b0, over = 1'b0;
   logic [15:0] score, high;
   logic        new_high, ms;
   logic [2:0]  level;

   // fast instance, one tick per point, used to reach saturation quickly
   logic        b_rst = 1'b1, b_tick = 1'b0, b_start = 1'b0, b_over = 1'b0;
   logic [15:0] b_score, b_high;
   logic        b_new_high, b_ms;
   logic [2:0]  b_level;

   score_counter #(.NUM_DIGITS(4), .TICKS_PER_POINT(TPP), .MAX_LEVEL(ML)) dut (
      .clk(clk), .rst(rst), .i_game_tick(tick), .i_game_start_pulse(start),
      .i_game_over_pulse(over), .o_score(score), .o_high_score(high),
      .o_new_high(new_high), .o_speed_level(level), .o_milestone_pulse(ms));

   score_counter #(.NUM_DIGITS(4), .TICKS_PER_POINT(1), .MAX_LEVEL(ML)) dut_fast (
      .clk(clk), .rst(b_rst), .i_game_tick(b_tick), .i_game_start_pulse(b_start),
      .i_game_over_pulse(b_over), .o_score(b_score), .o_high_score(b_high),
      .o_new_high(b_new_high), .o_speed_level(b_level), .o_milestone_pulse(b_ms));

   int checks = 0;
   int failures = 0;

   // reference model: plain integers, one update per clock edge
   int m_score = 0, m_high = 0, m_pre = 0, m_level = 0;
   bit m_run = 0, m_new_high = 0, m_ms = 0;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r = '0;
      for (int d = 0; d < 4; d++) r[4*d +: 4] = 4'((v / (10 ** d)) % 10);
      return r;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input bit t, input bit s, input bit o, input bit r);
      m_ms = 0;
      if (r) begin
         m_score = 0; m_high = 0; m_pre = 0; m_level = 0;
         m_run = 0; m_new_high = 0;
      end else if (s) begin
         m_run = 1; m_score = 0; m_pre = 0; m_level = 0; m_new_high = 0;
      end else if (m_run) begin
         if (o) begin
            m_run = 0;
            if (m_score > m_high) begin
               m_high = m_score;
               m_new_high = 1;
            end
         end else if (t) begin
            if (m_pre == TPP - 1) begin
               m_pre = 0;
               if (m_score < MAXS) begin
                  m_score++;
                  if (m_score % 100 == 0) begin
                     m_ms = 1;
                     if (m_level < ML) m_level++;
                  end
               end
            end else begin
               m_pre++;
            end
         end
      end
   endtask

   task automatic check_all();
      check("score", score, to_bcd(m_score));
      check("high_score", high, to_bcd(m_high));
      check("new_high", {15'b0, new_high}, {15'b0, m_new_high});
      check("speed_level", {13'b0, level}, 16'(m_level));
      check("milestone", {15'b0, ms}, {15'b0, m_ms});
   endtask

   // one clock: drive, let the edge happen, advance the model, compare
   task automatic step(input bit t, input bit s, input bit o, input bit r);
      tick = t; start = s; over = o; rst = r;
      @(posedge clk);
      model_update(t, s, o, r);
      #1;
      check_all();
      tick = 0; start = 0; over = 0; rst = 0;
   endtask

   task automatic ticks(input int n, input int gap_max);
      for (int i = 0; i < n; i++) begin
         for (int g = $urandom_range(0, gap_max); g > 0; g--) step(0, 0, 0, 0);
         step(1, 0, 0, 0);
      end
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (m_score != target && guard < 20000) begin
         step($urandom_range(0, 3) != 0, 0, 0, 0);
         guard++;
      end
      checks++;
      assert (m_score == target) else begin
         failures++;
         $error("FAIL run_to_timeout observed=%0d expected=%0d", m_score, target);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ms_cnt, sat_cnt;

      // 1: reset, ticks and a crash with no game do nothing
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("t1_reset_score", score, 16'h0000);
      ticks(20, 0);
      step(0, 0, 1, 0);
      check("t1_idle_score", score, 16'h0000);
      check("t1_idle_level", {13'b0, level}, 16'd0);
      check("t1_idle_high", high, 16'h0000);

      // 2: 60 ticks with random gaps -> 10 points
      step(0, 1, 0, 0);
      check("t2_start_score", score, 16'h0000);
      ticks(60, 2);
      check("t2_score", score, 16'h0010);

      // 3: cross 99 -> 100, one milestone pulse, level 1
      run_to(99);
      ms_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0, 0);
         if (ms) ms_cnt++;
      end
      step(0, 0, 0, 0);
      if (ms) ms_cnt++;
      check("t3_score", score, 16'h0100);
      check("t3_level", {13'b0, level}, 16'd1);
      check("t3_ms_count", 16'(ms_cnt), 16'd1);

      // 4: high score set, then not beaten
      step(0, 1, 0, 0);
      run_to(42);
      step(0, 0, 1, 0);
      check("t4_high", high, 16'h0042);
      check("t4_new_high", {15'b0, new_high}, 16'd1);
      step(0, 1, 0, 0);
      check("t4_start_clears_new_high", {15'b0, new_high}, 16'd0);
      run_to(30);
      step(0, 0, 1, 0);
      check("t4_high_kept", high, 16'h0042);
      check("t4_no_new_high", {15'b0, new_high}, 16'd0);

      // 5: crash coincident with a point-completing tick, start+over, start+tick
      step(0, 1, 0, 0);
      run_to(7);
      for (int i = 0; i < TPP && m_pre != TPP - 1; i++) step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      check("t5_frozen", score, 16'h0007);
      ticks(8, 0);
      check("t5_over_ignores_ticks", score, 16'h0007);
      step(0, 1, 1, 0);
      check("t5_start_wins", score, 16'h0000);
      step(1, 1, 0, 0);
      ticks(TPP - 1, 1);
      check("t5_start_tick_dropped", score, 16'h0000);
      ticks(1, 0);
      check("t5_point_after_restart", score, 16'h0001);

      // random pulse mix against the model
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 1), $urandom_range(0, 99) == 0,
              $urandom_range(0, 79) == 0, $urandom_range(0, 499) == 0);

      // rst mid-game with every pulse present
      step(0, 1, 0, 0);
      ticks(20, 0);
      step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      ticks(13, 0);
      step(1, 1, 1, 1);
      check("rst_score", score, 16'h0000);
      check("rst_high", high, 16'h0000);

      // 6: saturation on the fast instance
      @(posedge clk); #1;
      b_rst = 1'b0; b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0; b_tick = 1'b1;
      ms_cnt = 0; sat_cnt = 0;
      for (int i = 0; i < MAXS + 12; i++) begin
         @(posedge clk); #1;
         if (b_ms) begin
            if (i >= MAXS) sat_cnt++;
            else ms_cnt++;
         end
      end
      b_tick = 1'b0;
      check("t6_saturated", b_score, 16'h9999);
      check("t6_ms_total", 16'(ms_cnt), 16'd99);
      check("t6_ms_on_sat", 16'(sat_cnt), 16'd0);
      check("t6_level_sat", {13'b0, b_level}, 16'(ML));
      b_over = 1'b1;
      @(posedge clk); #1;
      b_over = 1'b0;
      check("t6_high", b_high, 16'h9999);
      check("t6_new_high", {15'b0, b_new_high}, 16'd1);
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0; b_tick = 1'b1;
      repeat (250) @(posedge clk);
      #1;
      check("t6_running_again", b_score, 16'h0250);
      b_rst = 1'b1; b_over = 1'b1;
      @(posedge clk); #1;
      b_rst = 1'b0; b_over = 1'b0; b_tick = 1'b0;
      check("t6_rst_score", b_score, 16'h0000);
      check("t6_rst_high", b_high, 16'h0000);
      check("t6_rst_new_high", {15'b0, b_new_high}, 16'd0);
      check("t6_rst_level", {13'b0, b_level}, 16'd0);
      check("t6_rst_ms", {15'b0, b_ms}, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
